call_dispatcher: RTL and testbench
==================================

Name: call_dispatcher

Overview:
- Consumer of the debounced per-floor call pulses.
- Latches pending calls, drives the call LEDs, and selects the next target floor using SCAN ordering (keep direction while calls remain ahead).
- Hands the target to the movement block over a valid/ready handshake, waits for the arrival pulse, then runs the door-open dwell.
- Sits between the button handler and movement; honours the SOS and weight-limit emergency flags.

Parameters:
- N_FLOORS, 3, number of floors (legal range 2..8); floor index 0 is the bottom floor.
- FLOOR_W, 2, width of the floor index; must satisfy 2^FLOOR_W >= N_FLOORS.
- DOOR_TICKS, 3, number of clk cycles the door stays open (clk is the divided slow clock).

Ports:
- clk  in  1  divided system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- call_pulse  in  N_FLOORS  one-cycle call pulse per floor from the button handler.
- sos  in  1  emergency freeze, level-sensitive.
- weight_over  in  1  weight limit exceeded, level-sensitive.
- cur_floor  in  FLOOR_W  current car floor reported by movement.
- arrived  in  1  one-cycle pulse from movement when the car has stopped at cur_floor.
- target_ready  in  1  movement accepts the target.
- target_floor  out  FLOOR_W  requested destination floor.
- target_valid  out  1  target_floor is valid.
- call_led  out  N_FLOORS  pending-call indicators; equals the pending register.
- door_open  out  1  door-open command.
- dir_up  out  1  current SCAN direction (1 = up).

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, reset_n).
- Reset values: pending=0, state=IDLE, target_floor=0, target_valid=0, door_open=0, dir_up=1, door counter=0.
- Pending register: pending[i] sets on call_pulse[i]. It clears only on service, i.e. on entry to DOOR for the floor served.
- Set/clear collision: when set and clear hit the same bit in the same cycle, clear wins.
- While in DOOR, call_pulse[cur_floor] is ignored because that floor is already being served.
- call_led mirrors pending combinationally from registers; zero added latency.
- IDLE, sos=0, pending[cur_floor]=1:
  - Go to DOOR next cycle.
  - Clear pending[cur_floor].
- IDLE, sos=0, other pending bits set:
  - Compute the next target by SCAN.
  - If dir_up, take the nearest pending floor above cur_floor; if there is none, set dir_up=0 and take the nearest pending floor below.
  - The symmetric rule applies when dir_up=0.
  - Register target_floor, assert target_valid, go to REQUEST. Latency from call_pulse to target_valid is 2 cycles (latch, select).
- REQUEST:
  - target_valid and target_floor are held stable until target_ready=1 is sampled.
  - On handshake: deassert target_valid, go to TRAVEL.
  - If sos=1 before the handshake: deassert target_valid, return to IDLE. This is the only permitted valid withdrawal.
- TRAVEL:
  - The target is fixed; new calls only latch.
  - arrived=1 with cur_floor==target_floor: clear pending[target_floor], go to DOOR.
  - arrived with a mismatched cur_floor is ignored; stay in TRAVEL.
  - sos has no effect in TRAVEL; movement owns motion.
- DOOR:
  - door_open=1 from the first DOOR cycle.
  - The counter counts 0..DOOR_TICKS-1 and then exits to IDLE with door_open=0.
  - If weight_over=1 or sos=1, the counter holds and the door stays open.
  - Counting resumes from the held value when both flags are clear.
  - The counter resets to 0 on every DOOR entry.
- sos=1 in IDLE: no dispatch and no door cycle. Pending calls still latch.
- Boundaries:
  - At the top floor with dir_up=1 and only lower calls pending, the direction flips in the same selection cycle. The bottom floor is symmetric.
  - Out-of-range cur_floor (>= N_FLOORS) is treated as no match; no pending bit changes.
- Reset mid-operation forces reset values immediately (asynchronous), including door_open=0 and target_valid=0.

Decomposition:
- Shared package elevator_pkg holds:
  - the state enum (IDLE, REQUEST, TRAVEL, DOOR);
  - the FLOOR_W and N_FLOORS defaults;
  - the SCAN-select function.
- One sub-module: scan_select. It is combinational; inputs are pending, cur_floor and dir_up; outputs are next_floor, next_dir and found. It is kept separate so it can be unit-tested exhaustively.

Test Plan:
- Reset, then idle: call_pulse=0 for 10 cycles -> all outputs stay at reset values; target_valid never asserts.
- cur_floor=0, pulse call[2]:
  - 2 cycles later target_valid=1 with target_floor=2, held while target_ready=0 for 4 cycles.
  - ready pulse -> TRAVEL.
  - arrived with cur_floor=2 -> door_open=1 for exactly 3 cycles; call_led[2] clears on DOOR entry.
- SCAN order: cur_floor=1, dir_up=1, pending={0,2} -> target=2 first; after service -> dir_up=0, target=0.
- Call at the current floor in IDLE (cur_floor=1, pulse call[1]) -> DOOR next cycle with no handshake; call_led[1]=0.
- weight_over=1 for 5 cycles during DOOR cycle 1 -> door_open stays high for 3+5 cycles total.
- SOS: assert sos while in REQUEST -> target_valid drops next cycle, state IDLE. Also during DOOR -> door stays open until sos=0.
- Reset: assert reset_n=0 while in DOOR -> door_open=0 asynchronously.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types, defaults and the SCAN floor-selection helper for the elevator
// control slice.
package elevator_pkg;

    localparam int unsigned DEFAULT_N_FLOORS = 3;
    localparam int unsigned DEFAULT_FLOOR_W  = 2;
    localparam int unsigned MAX_FLOORS       = 8;
    localparam int unsigned MAX_FLOOR_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        TRAVEL,
        DOOR
    } disp_state_t;

    typedef struct packed {
        logic                   found;
        logic                   dir_up;
        logic [MAX_FLOOR_W-1:0] floor;
    } scan_res_t;

    // Nearest pending floor in the current direction, reversing only when
    // nothing is pending ahead. The current floor itself is never picked.
    function automatic scan_res_t scan_pick(
        input logic [MAX_FLOORS-1:0] pend,
        input int unsigned           cur,
        input logic                  up
    );
        scan_res_t              res;
        logic                   has_above;
        logic                   has_below;
        logic [MAX_FLOOR_W-1:0] above;
        logic [MAX_FLOOR_W-1:0] below;

        has_above = 1'b0;
        has_below = 1'b0;
        above     = '0;
        below     = '0;
        for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
            if (pend[i] && (i > cur) && !has_above) begin
                has_above = 1'b1;
                above     = MAX_FLOOR_W'(i);
            end
            if (pend[i] && (i < cur)) begin
                has_below = 1'b1;
                below     = MAX_FLOOR_W'(i);
            end
        end

        res.found  = has_above | has_below;
        res.dir_up = up;
        res.floor  = '0;
        if (up) begin
            if (has_above) begin
                res.floor = above;
            end else if (has_below) begin
                res.floor  = below;
                res.dir_up = 1'b0;
            end
        end else begin
            if (has_below) begin
                res.floor = below;
            end else if (has_above) begin
                res.floor  = above;
                res.dir_up = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/call_dispatcher_scan_select.sv
// Combinational SCAN target selector: picks the next floor to serve from the
// pending calls, the current floor and the current travel direction.
module scan_select
    import elevator_pkg::*;
#(
    parameter int unsigned N_FLOORS = DEFAULT_N_FLOORS,
    parameter int unsigned FLOOR_W  = DEFAULT_FLOOR_W
) (
    input  logic [N_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]  cur_floor,
    input  logic                dir_up,
    output logic [FLOOR_W-1:0]  next_floor,
    output logic                next_dir,
    output logic                found
);

    logic [MAX_FLOORS-1:0] pend_ext;
    scan_res_t             res;

    always_comb begin
        pend_ext                 = '0;
        pend_ext[N_FLOORS-1:0]   = pending;
        res                      = scan_pick(pend_ext, 32'(cur_floor), dir_up);
        next_floor               = FLOOR_W'(res.floor);
        next_dir                 = res.dir_up;
        found                    = res.found;
    end

endmodule

// File: rtl/call_dispatcher.sv
// Latches floor calls, dispatches SCAN-ordered targets to the movement block
// over valid/ready, and runs the door dwell after each arrival.
module call_dispatcher
    import elevator_pkg::*;
#(
    parameter int unsigned N_FLOORS   = DEFAULT_N_FLOORS,
    parameter int unsigned FLOOR_W    = DEFAULT_FLOOR_W,
    parameter int unsigned DOOR_TICKS = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_FLOORS-1:0] call_pulse,
    input  logic                sos,
    input  logic                weight_over,
    input  logic [FLOOR_W-1:0]  cur_floor,
    input  logic                arrived,
    input  logic                target_ready,
    output logic [FLOOR_W-1:0]  target_floor,
    output logic                target_valid,
    output logic [N_FLOORS-1:0] call_led,
    output logic                door_open,
    output logic                dir_up
);

    localparam int unsigned CNT_W = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

    disp_state_t         state, state_nx;
    logic [N_FLOORS-1:0] pending, pending_nx;
    logic [N_FLOORS-1:0] pend_clr, set_mask;
    logic [N_FLOORS-1:0] cur_onehot;
    logic [FLOOR_W-1:0]  tgt_q, tgt_nx;
    logic                dir_q, dir_nx;
    logic [CNT_W-1:0]    cnt_q, cnt_nx;
    logic                cur_pend;
    logic [FLOOR_W-1:0]  sel_floor;
    logic                sel_dir;
    logic                sel_found;

    scan_select #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_scan (
        .pending    (pending),
        .cur_floor  (cur_floor),
        .dir_up     (dir_q),
        .next_floor (sel_floor),
        .next_dir   (sel_dir),
        .found      (sel_found)
    );

    // An out-of-range cur_floor decodes to all zeros, so it never matches.
    always_comb begin
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            cur_onehot[i] = (32'(cur_floor) == i);
        end
    end

    assign cur_pend = |(pending & cur_onehot);

    always_comb begin
        state_nx = state;
        tgt_nx   = tgt_q;
        dir_nx   = dir_q;
        cnt_nx   = cnt_q;
        pend_clr = '0;
        set_mask = '0;
        unique case (state)
            IDLE: begin
                if (!sos) begin
                    if (cur_pend) begin
                        state_nx = DOOR;
                        pend_clr = cur_onehot;
                        cnt_nx   = '0;
                    end else if (sel_found) begin
                        state_nx = REQUEST;
                        tgt_nx   = sel_floor;
                        dir_nx   = sel_dir;
                    end
                end
            end
            REQUEST: begin
                if (target_ready) begin
                    state_nx = TRAVEL;
                end else if (sos) begin
                    state_nx = IDLE;
                end
            end
            TRAVEL: begin
                if (arrived && (cur_floor == tgt_q)) begin
                    state_nx = DOOR;
                    pend_clr = cur_onehot;
                    cnt_nx   = '0;
                end
            end
            DOOR: begin
                set_mask = cur_onehot;
                if (!(weight_over || sos)) begin
                    if (cnt_q == CNT_W'(DOOR_TICKS - 1)) begin
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        pending_nx = (pending | (call_pulse & ~set_mask)) & ~pend_clr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pending <= '0;
            tgt_q   <= '0;
            dir_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
            tgt_q   <= tgt_nx;
            dir_q   <= dir_nx;
            cnt_q   <= cnt_nx;
        end
    end

    assign target_floor = tgt_q;
    assign target_valid = (state == REQUEST);
    assign door_open    = (state == DOOR);
    assign call_led     = pending;
    assign dir_up       = dir_q;

endmodule

// File: tb/tb_call_dispatcher.sv
// Directed bench for call_dispatcher with a phase/queue-level reference model
// compared every cycle, plus hand-computed literal checks.
module tb_call_dispatcher;

    localparam int NF = 3;
    localparam int FW = 2;
    localparam int DT = 3;

    localparam int PH_IDLE   = 0;
    localparam int PH_REQ    = 1;
    localparam int PH_TRAVEL = 2;
    localparam int PH_DOOR   = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NF-1:0] call_pulse = '0;
    logic          sos = 1'b0;
    logic          weight_over = 1'b0;
    logic [FW-1:0] cur_floor = '0;
    logic          arrived = 1'b0;
    logic          target_ready = 1'b0;
    logic [FW-1:0] target_floor;
    logic          target_valid;
    logic [NF-1:0] call_led;
    logic          door_open;
    logic          dir_up;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    int      m_phase     = PH_IDLE;
    bit [NF-1:0] m_pend  = '0;
    int      m_tgt       = 0;
    bit      m_up        = 1'b1;
    int      m_door_left = 0;

    call_dispatcher #(
        .N_FLOORS   (NF),
        .FLOOR_W    (FW),
        .DOOR_TICKS (DT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .call_pulse   (call_pulse),
        .sos          (sos),
        .weight_over  (weight_over),
        .cur_floor    (cur_floor),
        .arrived      (arrived),
        .target_ready (target_ready),
        .target_floor (target_floor),
        .target_valid (target_valid),
        .call_led     (call_led),
        .door_open    (door_open),
        .dir_up       (dir_up)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phases, a pending bit set, door countdown, and SCAN
    // chosen by distance to the nearest call on each side.
    task automatic model_step();
        int          cf;
        bit [NF-1:0] nxt;
        bit [NF-1:0] sets;
        int          up_d, dn_d, up_f, dn_f, d;
        cf   = int'(cur_floor);
        sets = call_pulse;
        if (m_phase == PH_DOOR && cf < NF) sets[cf] = 1'b0;
        nxt  = m_pend | sets;
        case (m_phase)
            PH_IDLE: if (!sos) begin
                if (cf < NF && m_pend[cf]) begin
                    nxt[cf] = 1'b0;
                    m_phase = PH_DOOR;
                    m_door_left = DT;
                end else begin
                    up_d = -1; dn_d = -1; up_f = 0; dn_f = 0;
                    for (int f = 0; f < NF; f++) begin
                        if (m_pend[f]) begin
                            d = f - cf;
                            if (d > 0 && (up_d < 0 || d < up_d)) begin up_d = d; up_f = f; end
                            if (d < 0 && (dn_d < 0 || -d < dn_d)) begin dn_d = -d; dn_f = f; end
                        end
                    end
                    if (m_up) begin
                        if (up_d > 0) begin m_tgt = up_f; m_phase = PH_REQ; end
                        else if (dn_d > 0) begin m_tgt = dn_f; m_up = 1'b0; m_phase = PH_REQ; end
                    end else begin
                        if (dn_d > 0) begin m_tgt = dn_f; m_phase = PH_REQ; end
                        else if (up_d > 0) begin m_tgt = up_f; m_up = 1'b1; m_phase = PH_REQ; end
                    end
                end
            end
            PH_REQ: begin
                if (target_ready) m_phase = PH_TRAVEL;
                else if (sos) m_phase = PH_IDLE;
            end
            PH_TRAVEL: if (arrived && cf == m_tgt) begin
                nxt[cf] = 1'b0;
                m_phase = PH_DOOR;
                m_door_left = DT;
            end
            PH_DOOR: if (!(weight_over || sos)) begin
                m_door_left--;
                if (m_door_left == 0) m_phase = PH_IDLE;
            end
            default: m_phase = PH_IDLE;
        endcase
        m_pend = nxt;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = PH_IDLE;
            m_pend = '0;
            m_tgt = 0;
            m_up = 1'b1;
            m_door_left = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("cmp_valid", target_valid, m_phase == PH_REQ);
            check("cmp_door", door_open, m_phase == PH_DOOR);
            check("cmp_led", call_led, m_pend);
            check("cmp_dir", dir_up, m_up);
            if (m_phase == PH_REQ) check("cmp_tgt", target_floor, m_tgt);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(input logic [NF-1:0] v);
        call_pulse = v;
        tick(1);
        call_pulse = '0;
    endtask

    task automatic handshake();
        target_ready = 1'b1;
        tick(1);
        target_ready = 1'b0;
    endtask

    task automatic arrive(input logic [FW-1:0] f);
        cur_floor = f;
        arrived = 1'b1;
        tick(1);
        arrived = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!target_valid && n < 10) begin
            tick(1);
            n++;
        end
        check(name, target_valid, 1);
    endtask

    task automatic wait_door_end(input string name);
        int n;
        n = 0;
        while (door_open && n < 30) begin
            tick(1);
            n++;
        end
        check(name, door_open, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n;
        tick(2);
        reset_n = 1'b1;
        check_en = 1'b1;
        check("rst_valid", target_valid, 0);
        check("rst_door", door_open, 0);
        check("rst_led", call_led, 0);
        check("rst_dir", dir_up, 1);
        check("rst_tgt", target_floor, 0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("idle_valid", target_valid, 0);
        end

        // Single call from the bottom floor.
        cur_floor = 2'd0;
        pulse(3'b100);
        check("s1_led", call_led, 3'b100);
        check("s1_valid_early", target_valid, 0);
        tick(1);
        check("s1_valid", target_valid, 1);
        check("s1_tgt", target_floor, 2);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("s1_hold_valid", target_valid, 1);
            check("s1_hold_tgt", target_floor, 2);
        end
        handshake();
        check("s1_travel_valid", target_valid, 0);
        check("s1_travel_door", door_open, 0);
        arrive(2'd2);
        check("s1_door", door_open, 1);
        check("s1_led_clr", call_led, 0);
        n = 1;
        tick(1);
        while (door_open && n < 20) begin
            n++;
            tick(1);
        end
        check("s1_door_len", n, 3);

        // SCAN ordering with a direction flip at the top floor.
        cur_floor = 2'd1;
        pulse(3'b101);
        check("s2_led", call_led, 3'b101);
        tick(1);
        check("s2_tgt_up", target_floor, 2);
        check("s2_dir_up", dir_up, 1);
        handshake();
        arrive(2'd2);
        wait_door_end("s2_door_end1");
        wait_valid("s2_valid2");
        check("s2_tgt_dn", target_floor, 0);
        check("s2_dir_dn", dir_up, 0);
        handshake();
        arrive(2'd0);
        weight_over = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            if (door_open) n++;
            tick(1);
        end
        weight_over = 1'b0;
        while (door_open && n < 30) begin
            n++;
            tick(1);
        end
        check("s2_weight_door_len", n, 8);

        // Call at the current floor, and a re-press while the door is open.
        cur_floor = 2'd1;
        pulse(3'b010);
        check("s3_led", call_led, 3'b010);
        check("s3_door_early", door_open, 0);
        tick(1);
        check("s3_door", door_open, 1);
        check("s3_led_clr", call_led, 0);
        check("s3_no_valid", target_valid, 0);
        pulse(3'b010);
        check("s3_ignored", call_led, 0);
        wait_door_end("s3_door_end");
        tick(2);
        check("s3_idle_valid", target_valid, 0);

        // Out-of-range floor, SOS in IDLE, mismatched arrival.
        cur_floor = 2'd3;
        sos = 1'b1;
        pulse(3'b010);
        tick(2);
        check("s4_led", call_led, 3'b010);
        check("s4_sos_valid", target_valid, 0);
        check("s4_sos_door", door_open, 0);
        sos = 1'b0;
        wait_valid("s4_valid");
        check("s4_tgt", target_floor, 1);
        check("s4_dir", dir_up, 0);
        handshake();
        arrive(2'd2);
        check("s4_mismatch_door", door_open, 0);
        check("s4_mismatch_led", call_led, 3'b010);
        arrive(2'd1);
        check("s4_door", door_open, 1);
        check("s4_led_clr", call_led, 0);
        wait_door_end("s4_door_end");

        // SOS withdraws a request, then freezes the door.
        pulse(3'b100);
        tick(1);
        check("s5_valid", target_valid, 1);
        check("s5_tgt", target_floor, 2);
        check("s5_dir_flip", dir_up, 1);
        sos = 1'b1;
        tick(1);
        check("s5_withdraw", target_valid, 0);
        pulse(3'b001);
        check("s5_led", call_led, 3'b101);
        tick(2);
        check("s5_sos_idle", target_valid, 0);
        sos = 1'b0;
        wait_valid("s5_valid2");
        check("s5_tgt2", target_floor, 2);
        handshake();
        arrive(2'd2);
        sos = 1'b1;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (door_open) n++;
            tick(1);
        end
        sos = 1'b0;
        while (door_open && n < 30) begin
            n++;
            tick(1);
        end
        check("s5_sos_door_len", n, 7);
        wait_valid("s5_valid3");
        check("s5_tgt3", target_floor, 0);
        check("s5_dir3", dir_up, 0);
        handshake();
        arrive(2'd0);
        check("s6_door", door_open, 1);

        // Asynchronous reset in the middle of the door dwell.
        #1;
        reset_n = 1'b0;
        #1;
        check("s6_rst_door", door_open, 0);
        check("s6_rst_valid", target_valid, 0);
        check("s6_rst_dir", dir_up, 1);
        check("s6_rst_led", call_led, 0);
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check("s6_post_door", door_open, 0);
        check("s6_post_valid", target_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
